// File: rtl/frame_receiver_if.sv
// frame_receiver_if: transmitter-side and consumer-side handshake signals of the frame receiver
//   slave  : the receiver's view (takes in_valid/in_data/out_ready, drives in_ready/ack/nak/out_data/out_valid)
//   master : the environment's view (mirror of slave)
interface frame_receiver_if;
  logic       in_valid;
  logic [9:0] in_data;
  logic       in_ready;
  logic       ack;
  logic       nak;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport slave (input in_valid, in_data, out_ready, output in_ready, ack, nak, out_data, out_valid);
  modport master(output in_valid, in_data, out_ready, input in_ready, ack, nak, out_data, out_valid);
endinterface

// File: rtl/frame_receiver.sv
// frame_receiver: parity-checking word receiver with ack/nak handshake feeding a FIFO
//   clk        : system clock, rising edge
//   clear_n    : asynchronous active-low reset
//   bus        : handshake bundle (slave view)
//   fifo_count : occupied FIFO entries
//   err_count  : saturating parity-failure count
//   overflow   : sticky, a good word was dropped on a full FIFO
module frame_receiver #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     clear_n,
  frame_receiver_if.slave          bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CW-1:0]            err_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  state_t        state_q, state_d;
  logic [9:0]    hold_q, hold_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] err_q, err_d;
  logic          ovf_q, ovf_d, ack_q, ack_d, nak_q, nak_d;
  logic          par_ok, full, wr, pop;
  logic [8:0]    mem_q [DEPTH];
  // Fullness is judged on the registered count, so a same-cycle pop never makes room for the write.
  assign par_ok = ~^hold_q;
  assign full   = cnt_q == (AW+1)'(DEPTH);
  assign pop    = bus.out_ready && cnt_q != '0;
  always_comb begin
    state_d  = state_q == IDLE ? (bus.in_valid ? CHECK : IDLE) : state_q == CHECK ? RESP : IDLE;
    hold_d   = state_q == IDLE && bus.in_valid ? bus.in_data : hold_q;
    wr       = state_q == CHECK && par_ok && !full;
    ack_d    = wr;
    nak_d    = state_q == CHECK && !(par_ok && !full);
    err_d    = state_q == CHECK && !par_ok ? err_q + CW'(!(&err_q)) : err_q;
    ovf_d    = ovf_q || (state_q == CHECK && par_ok && full);
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      nak_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
    end
  end
  // Storage is deliberately left unreset; the empty check on out_data hides stale entries.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= hold_q[8:0];
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.ack       = ack_q;
  assign bus.nak       = nak_q;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_data  = cnt_q != '0 ? mem_q[rd_ptr_q] : 9'h000;
  assign fifo_count    = cnt_q;
  assign err_count     = err_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_frame_receiver.sv
// tb_frame_receiver: directed self-checking bench for frame_receiver (DEPTH=4, CW=2)
module tb_frame_receiver;
  logic       clk = 1'b0;
  logic       clear_n;
  logic [2:0] fifo_count;
  logic [1:0] err_count;
  logic       overflow;
  int         checks = 0;
  int         failures = 0;
  logic       a_s, n_s, v_s;
  logic [2:0] c_s;
  logic [8:0] d_s;
  frame_receiver_if bus();
  frame_receiver #(.DEPTH(4), .CW(2)) dut (
    .clk(clk), .clear_n(clear_n), .bus(bus),
    .fifo_count(fifo_count), .err_count(err_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] mk(input logic [8:0] p);
    return {^p, p};
  endfunction
  // One transaction; out_ready is r_chk during CHECK and r_resp from RESP on. Samples taken in RESP.
  task automatic send(input logic [9:0] d, input logic r_chk, input logic r_resp);
    @(negedge clk);
    check("rdy_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = r_chk;
    check("rdy_check", 32'(bus.in_ready), 0);
    check("pulse_in_check", 32'({bus.ack, bus.nak}), 0);
    @(negedge clk);
    bus.out_ready = r_resp;
    a_s = bus.ack;
    n_s = bus.nak;
    c_s = fifo_count;
    d_s = bus.out_data;
    v_s = bus.out_valid;
  endtask
  task automatic pop1(input logic [8:0] exp);
    @(negedge clk);
    check("pop_valid", 32'(bus.out_valid), 1);
    check("pop_data", 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clear_n       = 1'b0;
    #3;
    check("rst_rdy", 32'(bus.in_ready), 1);
    check("rst_pulses", 32'({bus.ack, bus.nak}), 0);
    check("rst_oval", 32'(bus.out_valid), 0);
    check("rst_odata", 32'(bus.out_data), 0);
    check("rst_cnt", 32'(fifo_count), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    clear_n = 1'b1;
    // good word
    send(10'h0A5, 1'b0, 1'b0);
    check("good_ack", 32'({a_s, n_s}), 32'b10);
    check("good_cnt", 32'(c_s), 1);
    check("good_data", 32'(d_s), 32'h0A5);
    check("good_oval", 32'(v_s), 1);
    @(negedge clk);
    check("ack_one_cycle", 32'({bus.ack, bus.nak}), 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("popped_cnt", 32'(fifo_count), 0);
    check("empty_data", 32'(bus.out_data), 0);
    // empty pop has no effect
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("empty_pop_cnt", 32'(fifo_count), 0);
    // bad parity, then saturation at 3
    send(10'h2A5, 1'b0, 1'b0);
    check("bad_nak", 32'({a_s, n_s}), 32'b01);
    check("bad_err", 32'(err_count), 1);
    check("bad_cnt", 32'(c_s), 0);
    for (int i = 0; i < 4; i++) send(10'h2A5, 1'b0, 1'b0);
    check("err_sat", 32'(err_count), 3);
    check("bad_ovf", 32'(overflow), 0);
    // overflow
    for (int i = 1; i <= 5; i++) begin
      send(mk(9'(i)), 1'b0, 1'b0);
      check($sformatf("ovf_resp%0d", i), 32'({a_s, n_s}), i < 5 ? 32'b10 : 32'b01);
      check($sformatf("ovf_cnt%0d", i), 32'(c_s), i < 5 ? 32'(i) : 4);
    end
    check("ovf_flag", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) pop1(9'(i));
    check("ovf_drained", 32'(fifo_count), 0);
    // simultaneous write and pop
    send(mk(9'h010), 1'b0, 1'b0);
    send(mk(9'h011), 1'b0, 1'b0);
    send(mk(9'h012), 1'b0, 1'b0);
    send(mk(9'h013), 1'b1, 1'b0);
    check("sim3_ack", 32'({a_s, n_s}), 32'b10);
    check("sim3_cnt", 32'(c_s), 3);
    send(mk(9'h014), 1'b0, 1'b0);
    check("fill4_cnt", 32'(c_s), 4);
    send(mk(9'h015), 1'b1, 1'b0);
    check("simfull_nak", 32'({a_s, n_s}), 32'b01);
    check("simfull_cnt", 32'(c_s), 3);
    pop1(9'h012);
    pop1(9'h013);
    pop1(9'h014);
    check("ovf_sticky", 32'(overflow), 1);
    // asynchronous reset in the middle of CHECK
    send(mk(9'h1AA), 1'b0, 1'b0);
    check("pre_rst_oval", 32'(v_s), 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = mk(9'h0F0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    clear_n = 1'b0;
    #1;
    check("arst_rdy", 32'(bus.in_ready), 1);
    check("arst_pulses", 32'({bus.ack, bus.nak}), 0);
    check("arst_oval", 32'(bus.out_valid), 0);
    check("arst_odata", 32'(bus.out_data), 0);
    check("arst_cnt", 32'(fifo_count), 0);
    check("arst_err", 32'(err_count), 0);
    check("arst_ovf", 32'(overflow), 0);
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_pulses", 32'({bus.ack, bus.nak}), 0);
      check("post_rst_cnt", 32'(fifo_count), 0);
      check("post_rst_rdy", 32'(bus.in_ready), 1);
    end
    // wrap-around streaming with out_ready held high
    for (int i = 0; i < 10; i++) begin
      send(mk(9'h100 + 9'(i)), 1'b1, 1'b1);
      check($sformatf("wrap_ack%0d", i), 32'({a_s, n_s}), 32'b10);
      check($sformatf("wrap_cnt%0d", i), 32'(c_s), 1);
      check($sformatf("wrap_data%0d", i), 32'(d_s), 32'h100 + 32'(i));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("wrap_end_cnt", 32'(fifo_count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
